// File: rtl/mdu_iterative_if.sv
// Start/busy/done handshake plus result bundle between the core's MULDIV control and the MDU.
interface mdu_iterative_if #(
  parameter int XLEN = 32
);
  logic              start;
  logic              kill;
  logic [2:0]        funct3;
  logic [XLEN-1:0]   a;
  logic [XLEN-1:0]   b;
  logic              busy;
  logic              done;
  logic [XLEN-1:0]   result;
  logic [2*XLEN-1:0] product;
  logic [XLEN-1:0]   quotient;
  logic [XLEN-1:0]   remainder;

  modport master (
    output start, kill, funct3, a, b,
    input  busy, done, result, product, quotient, remainder
  );

  modport slave (
    input  start, kill, funct3, a, b,
    output busy, done, result, product, quotient, remainder
  );
endinterface

// File: rtl/mdu_iterative.sv
// Iterative RV32M/RV64M multiply/divide unit: radix-configurable shift-add multiply, restoring divide.
// Optional macro MDU_FAST_ZERO_EN short-circuits zero multiplies and divide-by-zero straight to FIX.
module mdu_iterative #(
  parameter int XLEN     = 32,
  parameter int MUL_STEP = 1
) (
  input logic           clk,
  input logic           rst,
  mdu_iterative_if.slave bus
);

  localparam int MUL_CYCLES = XLEN / MUL_STEP;
  localparam int CW         = $clog2(XLEN) + 1;
  localparam int PW         = XLEN + MUL_STEP;

  // ST_WB is the output-commit cycle after sign correction; it yields the N+2 latency.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_FIX,
    ST_WB
  } state_t;

  state_t state_reg, state_next;

  logic [2:0]        op_reg;
  logic              sign_a_reg, sign_b_reg, b_zero_reg;
  logic [XLEN-1:0]   a_reg, mag_a_reg, mag_b_reg;
  logic [2*XLEN-1:0] prod_reg;
  logic [XLEN-1:0]   quo_reg, rem_reg;
  logic [CW-1:0]     cnt_reg;

  logic [XLEN-1:0]   result_reg, quotient_reg, remainder_reg;
  logic [2*XLEN-1:0] product_reg;
  logic              done_reg;

  logic              in_sign_a, in_sign_b, in_skip, accept;
  logic [XLEN-1:0]   in_mag_a, in_mag_b;

  // Operand sign interpretation from funct3 of the incoming request.
  always_comb begin
    in_sign_a = (bus.funct3 inside {3'd1, 3'd2, 3'd4, 3'd6}) && bus.a[XLEN-1];
    in_sign_b = (bus.funct3 inside {3'd1, 3'd4, 3'd6}) && bus.b[XLEN-1];
    in_mag_a  = in_sign_a ? -bus.a : bus.a;
    in_mag_b  = in_sign_b ? -bus.b : bus.b;
`ifdef MDU_FAST_ZERO_EN
    in_skip   = bus.funct3[2] ? (bus.b == '0) : ((bus.a == '0) || (bus.b == '0));
`else
    in_skip   = 1'b0;
`endif
  end

  assign accept = (state_reg == ST_IDLE) && bus.start && !bus.kill;

  // Multiply step: add MUL_STEP partial products of the low multiplier digit into the high half.
  logic [MUL_STEP-1:0] mul_digit;
  logic [PW-1:0]       mul_pp [MUL_STEP];
  logic [PW-1:0]       mul_sum;

  assign mul_digit = prod_reg[MUL_STEP-1:0];

  generate
    for (genvar gi = 0; gi < MUL_STEP; gi++) begin : g_pp
      assign mul_pp[gi] = mul_digit[gi] ? ({{MUL_STEP{1'b0}}, mag_a_reg} << gi) : '0;
    end
  endgenerate

  always_comb begin
    mul_sum = {{MUL_STEP{1'b0}}, prod_reg[2*XLEN-1:XLEN]};
    for (int i = 0; i < MUL_STEP; i++) begin
      mul_sum = mul_sum + mul_pp[i];
    end
  end

  // Restoring divide step; quo_reg shifts the dividend out as quotient bits shift in.
  logic [XLEN:0]   div_shift;
  logic            div_ge;
  logic [XLEN-1:0] rem_next;

  always_comb begin
    div_shift = {rem_reg, quo_reg[XLEN-1]};
    div_ge    = div_shift >= {1'b0, mag_b_reg};
    rem_next  = div_ge ? (div_shift[XLEN-1:0] - mag_b_reg) : div_shift[XLEN-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (bus.start && !bus.kill) begin
          if (in_skip) begin
            state_next = ST_FIX;
          end else begin
            state_next = bus.funct3[2] ? ST_DIV : ST_MUL;
          end
        end
      end
      ST_MUL, ST_DIV: begin
        if (cnt_reg == '0) begin
          state_next = ST_FIX;
        end
      end
      ST_FIX:  state_next = ST_WB;
      ST_WB:   state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
    if (bus.kill && (state_reg != ST_IDLE)) begin
      state_next = ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_reg     <= '0;
      sign_a_reg <= 1'b0;
      sign_b_reg <= 1'b0;
      b_zero_reg <= 1'b0;
      a_reg      <= '0;
      mag_a_reg  <= '0;
      mag_b_reg  <= '0;
      prod_reg   <= '0;
      quo_reg    <= '0;
      rem_reg    <= '0;
      cnt_reg    <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            op_reg     <= bus.funct3;
            sign_a_reg <= in_sign_a;
            sign_b_reg <= in_sign_b;
            b_zero_reg <= (bus.b == '0);
            a_reg      <= bus.a;
            mag_a_reg  <= in_mag_a;
            mag_b_reg  <= in_mag_b;
            prod_reg   <= in_skip ? '0 : {{XLEN{1'b0}}, in_mag_b};
            quo_reg    <= in_mag_a;
            rem_reg    <= '0;
            cnt_reg    <= bus.funct3[2] ? CW'(XLEN - 1) : CW'(MUL_CYCLES - 1);
          end
        end
        ST_MUL: begin
          prod_reg <= {mul_sum, prod_reg[XLEN-1:MUL_STEP]};
          cnt_reg  <= cnt_reg - CW'(1);
        end
        ST_DIV: begin
          rem_reg <= rem_next;
          quo_reg <= {quo_reg[XLEN-2:0], div_ge};
          cnt_reg <= cnt_reg - CW'(1);
        end
        ST_FIX: begin
          if (sign_a_reg ^ sign_b_reg) begin
            prod_reg <= -prod_reg;
          end
          // Division by zero is forced so signed and unsigned agree regardless of sign fix-up.
          if (b_zero_reg) begin
            quo_reg <= '1;
            rem_reg <= a_reg;
          end else begin
            quo_reg <= (sign_a_reg ^ sign_b_reg) ? -quo_reg : quo_reg;
            rem_reg <= sign_a_reg ? -rem_reg : rem_reg;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs only change on an un-killed commit, so a flush leaves the previous results visible.
  always_ff @(posedge clk) begin
    if (rst) begin
      result_reg    <= '0;
      product_reg   <= '0;
      quotient_reg  <= '0;
      remainder_reg <= '0;
      done_reg      <= 1'b0;
    end else begin
      done_reg <= (state_reg == ST_WB) && !bus.kill;
      if ((state_reg == ST_WB) && !bus.kill) begin
        if (!op_reg[2]) begin
          product_reg <= prod_reg;
        end else begin
          quotient_reg  <= quo_reg;
          remainder_reg <= rem_reg;
        end
        case (op_reg)
          3'd0:                result_reg <= prod_reg[XLEN-1:0];
          3'd1, 3'd2, 3'd3:    result_reg <= prod_reg[2*XLEN-1:XLEN];
          3'd4, 3'd5:          result_reg <= quo_reg;
          default:             result_reg <= rem_reg;
        endcase
      end
    end
  end

  assign bus.busy      = (state_reg != ST_IDLE);
  assign bus.done      = done_reg;
  assign bus.result    = result_reg;
  assign bus.product   = product_reg;
  assign bus.quotient  = quotient_reg;
  assign bus.remainder = remainder_reg;

endmodule
